// File: rtl/backbone_pkg.sv
// Shared widths and enumerations for the processing-element backbone.
package backbone_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;

  typedef enum logic {
    PE_OS = 1'b0,
    PE_WS = 1'b1
  } pe_mode_e;

  typedef enum logic {
    PD_IDLE  = 1'b0,
    PD_DRAIN = 1'b1
  } pe_drain_state_e;

endpackage

// File: rtl/pe_sat_add.sv
// Signed adder with overflow detection and optional clamp to the representable range.
module pe_sat_add #(
  parameter int ACC_W_P  = 16,
  parameter int SAT_EN_P = 1
) (
  input  logic signed [ACC_W_P-1:0] a,
  input  logic signed [ACC_W_P-1:0] b,
  output logic signed [ACC_W_P-1:0] sum,
  output logic                      ovf
);

  localparam logic signed [ACC_W_P-1:0] MAX_VAL = {1'b0, {(ACC_W_P-1){1'b1}}};
  localparam logic signed [ACC_W_P-1:0] MIN_VAL = {1'b1, {(ACC_W_P-1){1'b0}}};

  logic signed [ACC_W_P-1:0] raw_sum;

  // Overflow happens only when both operands share a sign the result does not.
  always_comb begin
    raw_sum = a + b;
    ovf     = (a[ACC_W_P-1] == b[ACC_W_P-1]) && (raw_sum[ACC_W_P-1] != a[ACC_W_P-1]);
    sum     = raw_sum;
    if ((SAT_EN_P != 0) && ovf) begin
      sum = a[ACC_W_P-1] ? MIN_VAL : MAX_VAL;
    end
  end

endmodule

// File: rtl/pe_2d_mx.sv
// Systolic MAC processing element: output-stationary or weight-stationary,
// with a double-buffered drain shift chain for the accumulator.
import backbone_pkg::*;

module pe_2d_mx #(
  parameter int DATA_W_P    = DATA_W,
  parameter int ACC_W_P     = ACC_W,
  parameter int SAT_EN_P    = 1,
  parameter int DRAIN_LEN_P = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mode_i,
  input  logic                       clear_i,
  input  logic                       valid_i,
  input  logic signed [DATA_W_P-1:0] a_i,
  input  logic signed [DATA_W_P-1:0] b_i,
  output logic signed [DATA_W_P-1:0] a_o,
  output logic signed [DATA_W_P-1:0] b_o,
  output logic                       valid_o,
  input  logic                       wload_i,
  input  logic signed [ACC_W_P-1:0]  psum_i,
  output logic signed [ACC_W_P-1:0]  psum_o,
  input  logic                       drain_i,
  input  logic                       shift_i,
  input  logic signed [ACC_W_P-1:0]  chain_i,
  output logic signed [ACC_W_P-1:0]  chain_o,
  output logic                       sat_o,
  output logic                       busy_o
);

  // The product must fit in the accumulator without truncation.
  generate
    if (ACC_W_P < 2*DATA_W_P) begin : g_bad_width
      $error("pe_2d_mx: ACC_W_P must be at least 2*DATA_W_P");
    end
  endgenerate

  localparam int CNT_W = $clog2(DRAIN_LEN_P + 1);

  pe_mode_e                    mode;
  pe_drain_state_e             state_reg;
  logic [CNT_W-1:0]            cnt_reg;
  logic signed [DATA_W_P-1:0]  w_reg;
  logic signed [DATA_W_P-1:0]  mul_b;
  logic signed [2*DATA_W_P-1:0] prod;
  logic signed [ACC_W_P-1:0]   prod_ext;
  logic signed [ACC_W_P-1:0]   acc_reg;
  logic signed [ACC_W_P-1:0]   chain_reg;
  logic signed [ACC_W_P-1:0]   acc_sum;
  logic signed [ACC_W_P-1:0]   psum_sum;
  logic                        acc_ovf;
  logic                        psum_ovf;
  logic                        capture;
  logic                        os_mac;

  assign mode     = pe_mode_e'(mode_i);
  assign mul_b    = (mode == PE_WS) ? w_reg : b_i;
  assign prod     = a_i * mul_b;
  assign prod_ext = ACC_W_P'(prod);
  assign capture  = drain_i && (state_reg == PD_IDLE);
  assign os_mac   = valid_i && (mode == PE_OS);
  assign chain_o  = chain_reg;

  pe_sat_add #(.ACC_W_P(ACC_W_P), .SAT_EN_P(SAT_EN_P)) u_acc_add (
    .a   (acc_reg),
    .b   (prod_ext),
    .sum (acc_sum),
    .ovf (acc_ovf)
  );

  pe_sat_add #(.ACC_W_P(ACC_W_P), .SAT_EN_P(SAT_EN_P)) u_psum_add (
    .a   (psum_i),
    .b   (prod_ext),
    .sum (psum_sum),
    .ovf (psum_ovf)
  );

  // Systolic forwarding of operands and their qualifier to the neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_o     <= '0;
      b_o     <= '0;
      valid_o <= 1'b0;
    end else begin
      a_o     <= a_i;
      b_o     <= b_i;
      valid_o <= valid_i;
    end
  end

  // Stationary weight and the WS partial-sum pipeline stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_reg  <= '0;
      psum_o <= '0;
    end else if (mode == PE_WS) begin
      if (wload_i) begin
        w_reg <= b_i;
      end
      psum_o <= valid_i ? psum_sum : psum_i;
    end
  end

  // OS accumulator: a clear or a drain capture restarts it with this beat's product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (clear_i || capture) begin
      acc_reg <= os_mac ? prod_ext : '0;
    end else if (os_mac) begin
      acc_reg <= acc_sum;
    end
  end

  // Sticky overflow flag, cleared only when a new accumulation starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_o <= 1'b0;
    end else if (clear_i) begin
      sat_o <= 1'b0;
    end else if (mode == PE_WS) begin
      if (valid_i && psum_ovf) begin
        sat_o <= 1'b1;
      end
    end else if (os_mac && !capture && acc_ovf) begin
      sat_o <= 1'b1;
    end
  end

  // Drain FSM: capture the accumulator, then count shifts through the column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= PD_IDLE;
      cnt_reg   <= '0;
      chain_reg <= '0;
      busy_o    <= 1'b0;
    end else begin
      case (state_reg)
        PD_IDLE: begin
          if (drain_i) begin
            chain_reg <= acc_reg;
            cnt_reg   <= '0;
            state_reg <= PD_DRAIN;
            busy_o    <= 1'b1;
          end else if (shift_i) begin
            chain_reg <= chain_i;
          end
        end
        PD_DRAIN: begin
          if (shift_i) begin
            chain_reg <= chain_i;
            if (cnt_reg == CNT_W'(DRAIN_LEN_P - 1)) begin
              cnt_reg   <= '0;
              state_reg <= PD_IDLE;
              busy_o    <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= PD_IDLE;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_2d_mx.sv
// Directed bench for pe_2d_mx: OS/WS MACs, saturation vs wrap, drain chain and reset.
module tb_pe_2d_mx;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mode_i, clear_i, valid_i, wload_i, drain_i, shift_i;
  logic signed [7:0]  a_i, b_i;
  logic signed [15:0] psum_i, chain_i;

  logic signed [7:0]  a_o0, b_o0, a_o1, b_o1;
  logic               valid_o0, valid_o1, sat_o0, sat_o1, busy_o0, busy_o1;
  logic signed [15:0] psum_o0, psum_o1, chain_o0, chain_o1;

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  always #5 clk = ~clk;

  pe_2d_mx #(.DATA_W_P(8), .ACC_W_P(16), .SAT_EN_P(1), .DRAIN_LEN_P(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .clear_i(clear_i), .valid_i(valid_i),
    .a_i(a_i), .b_i(b_i), .a_o(a_o0), .b_o(b_o0), .valid_o(valid_o0),
    .wload_i(wload_i), .psum_i(psum_i), .psum_o(psum_o0),
    .drain_i(drain_i), .shift_i(shift_i), .chain_i(chain_i), .chain_o(chain_o0),
    .sat_o(sat_o0), .busy_o(busy_o0)
  );

  pe_2d_mx #(.DATA_W_P(8), .ACC_W_P(16), .SAT_EN_P(0), .DRAIN_LEN_P(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .clear_i(clear_i), .valid_i(valid_i),
    .a_i(a_i), .b_i(b_i), .a_o(a_o1), .b_o(b_o1), .valid_o(valid_o1),
    .wload_i(wload_i), .psum_i(psum_i), .psum_o(psum_o1),
    .drain_i(drain_i), .shift_i(shift_i), .chain_i(chain_i), .chain_o(chain_o1),
    .sat_o(sat_o1), .busy_o(busy_o1)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    step_no++;
    $display("step %0d: mode=%0b clr=%0b v=%0b a=%0d b=%0d drain=%0b shift=%0b chain_o=%0d busy=%0b sat=%0b/%0b psum_o=%0d",
             step_no, mode_i, clear_i, valid_i, a_i, b_i, drain_i, shift_i, chain_o0, busy_o0,
             sat_o0, sat_o1, psum_o0);
  endtask

  // Four shifts from IDLE-after-capture; chain_o follows chain_i, busy drops on the 4th.
  task automatic run_shifts(input int base);
    shift_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chain_i = 16'(base + k);
      tick();
      chk("shift_chain", chain_o0, base + k);
      chk("shift_busy", busy_o0, (k < 4) ? 1 : 0);
    end
    shift_i = 1'b0;
    chain_i = '0;
  endtask

  initial begin
    rst_n = 1'b0; mode_i = 1'b0; clear_i = 1'b0; valid_i = 1'b0; wload_i = 1'b0;
    drain_i = 1'b0; shift_i = 1'b0; a_i = '0; b_i = '0; psum_i = '0; chain_i = '0;

    // Reset state
    #1;
    chk("rst_a_o", a_o0, 0);
    chk("rst_valid_o", valid_o0, 0);
    chk("rst_psum_o", psum_o0, 0);
    chk("rst_chain_o", chain_o0, 0);
    chk("rst_sat_o", sat_o0, 0);
    chk("rst_busy_o", busy_o0, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // OS: 3*4 loaded on clear, then -2*5 accumulated -> 2
    clear_i = 1'b1; valid_i = 1'b1; a_i = 3; b_i = 4;
    tick();
    chk("os_a_o", a_o0, 3);
    chk("os_b_o", b_o0, 4);
    chk("os_valid_o", valid_o0, 1);
    clear_i = 1'b0; a_i = -2; b_i = 5;
    tick();
    chk("os_a_o_neg", a_o0, -2);
    valid_i = 1'b0; a_i = 0; b_i = 0; drain_i = 1'b1;
    tick();
    chk("os_acc_drain", chain_o0, 2);
    chk("os_busy", busy_o0, 1);
    chk("os_sat", sat_o0, 0);
    drain_i = 1'b0;
    run_shifts(0);

    // Drain with a coincident MAC: capture 55, acc restarts at 2*3
    clear_i = 1'b1; valid_i = 1'b1; a_i = 5; b_i = 11;
    tick();
    clear_i = 1'b0; drain_i = 1'b1; a_i = 2; b_i = 3;
    tick();
    chk("drain_capture", chain_o0, 55);
    chk("drain_busy", busy_o0, 1);
    valid_i = 1'b0; a_i = 0; b_i = 0;
    // drain_i held during the first shift must be ignored
    shift_i = 1'b1; chain_i = 21;
    tick();
    chk("drain_ignored", chain_o0, 21);
    drain_i = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      chain_i = 16'(20 + k);
      tick();
      chk("drain2_chain", chain_o0, 20 + k);
    end
    chk("drain2_idle", busy_o0, 0);
    shift_i = 1'b0;
    drain_i = 1'b1;
    tick();
    chk("double_buf_acc", chain_o0, 6);
    drain_i = 1'b0;
    run_shifts(10);

    // drain_i and shift_i together in IDLE: capture wins
    valid_i = 1'b1; a_i = 4; b_i = 4;
    tick();
    valid_i = 1'b0; a_i = 0; b_i = 0;
    drain_i = 1'b1; shift_i = 1'b1; chain_i = 99;
    tick();
    chk("drain_prio_chain", chain_o0, 16);
    chk("drain_prio_busy", busy_o0, 1);
    drain_i = 1'b0;

    // Async reset after two drain shifts
    valid_i = 1'b1; a_i = 1; b_i = 1; chain_i = 7;
    tick();
    chain_i = 8;
    tick();
    chk("pre_rst_chain", chain_o0, 8);
    chk("pre_rst_busy", busy_o0, 1);
    shift_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a_o", a_o0, 0);
    chk("mid_rst_valid_o", valid_o0, 0);
    chk("mid_rst_chain", chain_o0, 0);
    chk("mid_rst_busy", busy_o0, 0);
    valid_i = 1'b0; a_i = 0; b_i = 0; chain_i = 0;
    tick();
    rst_n = 1'b1; drain_i = 1'b1;
    tick();
    chk("post_rst_drain_busy", busy_o0, 1);
    chk("post_rst_chain", chain_o0, 0);
    drain_i = 1'b0;
    run_shifts(30);

    // Saturation vs wrap: three beats of 127*127
    clear_i = 1'b1; valid_i = 1'b1; a_i = 127; b_i = 127;
    tick();
    clear_i = 1'b0;
    tick();
    chk("sat_not_yet", sat_o0, 0);
    tick();
    chk("sat_flag_sat", sat_o0, 1);
    chk("sat_flag_wrap", sat_o1, 1);
    valid_i = 1'b0; a_i = 0; b_i = 0; drain_i = 1'b1;
    tick();
    chk("sat_acc_clamp", chain_o0, 32767);
    chk("sat_acc_wrap", chain_o1, -17149);
    drain_i = 1'b0;
    run_shifts(40);
    clear_i = 1'b1;
    tick();
    chk("sat_cleared", sat_o0, 0);
    chk("wrap_cleared", sat_o1, 0);

    // WS: weight 6, then 7*6+100; reload with coincident MAC uses old weight
    mode_i = 1'b1; wload_i = 1'b1; b_i = 6;
    tick();
    clear_i = 1'b0; wload_i = 1'b0; b_i = 0; valid_i = 1'b1; a_i = 7; psum_i = 100;
    tick();
    chk("ws_psum", psum_o0, 142);
    chk("ws_psum_wrapdut", psum_o1, 142);
    wload_i = 1'b1; b_i = 9;
    tick();
    chk("ws_old_weight", psum_o0, 142);
    wload_i = 1'b0; b_i = 0;
    tick();
    chk("ws_new_weight", psum_o0, 163);
    valid_i = 1'b0; psum_i = 50;
    tick();
    chk("ws_passthru", psum_o0, 50);
    chk("ws_sat", sat_o0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
